// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and defaults for the LSU request queue controller
package lsu_pkg;
    localparam int LSU_FIFOWIDE = 23;
    localparam int LSU_DEPTH = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FLUSH = 2'd2} state_t;
    typedef enum logic {REQ_LD = 1'b0, REQ_ST = 1'b1} req_id_t;
endpackage

// File: rtl/lsu_rr_arb2.sv
// lsu_rr_arb2: two-way round-robin arbiter; grant[0]=load, grant[1]=store
module lsu_rr_arb2
    import lsu_pkg::*;
(
    input  logic       Clk,
    input  logic       Rest,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    req_id_t rr_last;
    assign grant[0] = enable && valid[0] && (!valid[1] || rr_last == REQ_ST);
    assign grant[1] = enable && valid[1] && (!valid[0] || rr_last == REQ_LD);
    // load wins the first tie out of reset
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) rr_last <= REQ_ST;
        else if (|grant) rr_last <= grant[1] ? REQ_ST : REQ_LD;
    end
endmodule

// File: rtl/lsu_queue_ctrl.sv
// lsu_queue_ctrl: arbitrates load/store into the request FIFO, drains its head
// to the dcache over req/ack, and turns flushes into a one-cycle FIFO clean.
module lsu_queue_ctrl
    import lsu_pkg::*;
#(
    parameter int FIFOWIDE = LSU_FIFOWIDE,
    parameter int DEPTH = LSU_DEPTH,
    parameter int CNTW = 5
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                LdValid,
    input  logic [FIFOWIDE-1:0] LdData,
    output logic                LdReady,
    input  logic                StValid,
    input  logic [FIFOWIDE-1:0] StData,
    output logic                StReady,
    input  logic                Flush,
    output logic                FlushDone,
    output logic                FifoWable,
    output logic [FIFOWIDE-1:0] FifoDin,
    output logic                FifoRable,
    output logic                FifoClean,
    input  logic [FIFOWIDE-1:0] FifoPreOut,
    input  logic                FifoEmpty,
    output logic                MemReq,
    output logic [FIFOWIDE-1:0] MemData,
    input  logic                MemAck,
    output logic [CNTW-1:0]     Count
);
    state_t state, state_nxt;
    logic flush_pend, go_flush, enq_en;
    logic [1:0] grant;
    assign go_flush = flush_pend || Flush;
    assign enq_en = (Count < CNTW'(DEPTH)) && !flush_pend && state != FLUSH;
    lsu_rr_arb2 u_arb (
        .Clk    (Clk),
        .Rest   (Rest),
        .valid  ({StValid, LdValid}),
        .enable (enq_en),
        .grant  (grant)
    );
    assign LdReady = grant[0];
    assign StReady = grant[1];
    assign FifoWable = |grant;
    assign FifoDin = grant[1] ? StData : LdData;
    // after an ack we pass through IDLE so the new head is captured cleanly
    always_comb begin
        state_nxt = state;
        MemReq = 1'b0;
        FifoRable = 1'b0;
        FifoClean = 1'b0;
        case (state)
            IDLE: state_nxt = go_flush ? FLUSH : (Count != '0) ? REQ : IDLE;
            REQ: begin
                MemReq = 1'b1;
                FifoRable = MemAck;
                state_nxt = !MemAck ? REQ : go_flush ? FLUSH : IDLE;
            end
            FLUSH: begin
                FifoClean = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state <= IDLE;
            Count <= '0;
            flush_pend <= 1'b0;
            FlushDone <= 1'b0;
            MemData <= '0;
        end else begin
            state <= state_nxt;
            Count <= FifoClean ? '0 : Count + CNTW'(FifoWable) - CNTW'(FifoRable);
            flush_pend <= FifoClean ? 1'b0 : go_flush;
            FlushDone <= FifoClean;
            if (state == IDLE && state_nxt == REQ) MemData <= FifoPreOut;
        end
    end
    a_no_pop_empty: assert property (@(posedge Clk) disable iff (!Rest) FifoRable |-> Count != '0);
    a_count_max: assert property (@(posedge Clk) disable iff (!Rest) Count <= CNTW'(DEPTH));
    a_empty_match: assert property (@(posedge Clk) disable iff (!Rest) state != FLUSH |-> FifoEmpty == (Count == '0));
    a_req_hold: assert property (@(posedge Clk) disable iff (!Rest) MemReq && !MemAck |=> MemReq);
endmodule
